// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory/cache port between the instruction-fetch (IM) side and
// the MEM-stage data (DM) side. The granted request is latched into the
// mem_* registers and held there until the memory reports completion. The
// read data and a one-cycle ack then go back to the winner.
//
// Handshake: a requester raises *_req with its fields and keeps them until
// it sees *_ack=1. The ack is high for exactly one cycle (the RESP state).
// The requester may drop or change its request at the end of that cycle.
// mem_req stays high, with every mem_* field constant, until mem_valid
// (a one-cycle pulse) completes the access.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   im_*            fetch request/address in, ack/read data out
//   dm_*            data request/write/type/address/store data in,
//                   ack/raw load data out
//   mem_*           shared port: registered request fields out,
//                   read data and completion pulse in
//   core_stall      high while either requester is still waiting
//   state           debug: current FSM state (0 IDLE, 1 BUSY_IM,
//                   2 BUSY_DM, 3 RESP)
//   dm_streak       debug: consecutive DM grants made while IM was waiting
module mem_port_arbiter #(
  parameter int MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic        im_ack,
  output logic [31:0] im_rdata,
  input  logic        dm_req,
  input  logic        dm_write,
  input  logic [2:0]  dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        core_stall,
  output logic [1:0]  state,
  output logic [3:0]  dm_streak
);

  // Access type codes shared with the cache and the MEM stage.
  localparam logic [2:0] CACHE_BYTE    = 3'b000;
  localparam logic [2:0] CACHE_HWORD   = 3'b001;
  localparam logic [2:0] CACHE_WORD    = 3'b010;
  localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
  localparam logic [2:0] CACHE_HWORD_U = 3'b101;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IM = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t fsm;

  // DM wins a tie unless it has already taken MAX_DM_BURST grants in a row
  // while IM was waiting.
  logic dm_wins;
  assign dm_wins = dm_req && !(im_req && (dm_streak == STREAK_MAX));

  assign core_stall = (im_req & ~im_ack) | (dm_req & ~dm_ack);
  assign state      = fsm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_type  <= CACHE_WORD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      im_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      im_rdata  <= '0;
      dm_rdata  <= '0;
      dm_streak <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (dm_wins) begin
            fsm       <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_write <= dm_write;
            mem_type  <= dm_type;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Only grants that make IM wait count towards the burst limit.
            if (im_req) begin
              dm_streak <= (dm_streak >= STREAK_MAX) ? STREAK_MAX
                                                     : dm_streak + 4'd1;
            end else begin
              dm_streak <= '0;
            end
          end else if (im_req) begin
            fsm       <= BUSY_IM;
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_type  <= CACHE_WORD;
            mem_addr  <= im_addr;
            mem_wdata <= '0;
            dm_streak <= '0;
          end
        end
        BUSY_IM: begin
          if (mem_valid) begin
            fsm      <= RESP;
            mem_req  <= 1'b0;
            im_rdata <= mem_rdata;
            im_ack   <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_valid) begin
            fsm     <= RESP;
            mem_req <= 1'b0;
            // The latched write flag decides, not the live dm_write input.
            if (!mem_write) begin
              dm_rdata <= mem_rdata;
            end
            dm_ack  <= 1'b1;
          end
        end
        RESP: begin
          // One ack cycle; no new grant so the requester can update its req.
          fsm    <= IDLE;
          im_ack <= 1'b0;
          dm_ack <= 1'b0;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

  // Codes not referenced by the arbiter itself are kept for documentation of
  // the type field that is passed through unmodified.
  logic unused_codes;
  assign unused_codes = ^{CACHE_HWORD, CACHE_BYTE_U, CACHE_HWORD_U};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared memory/cache port between two requesters: the instruction-fetch (IM) side and the MEM-stage data (DM) side.
- Registers the granted request's fields and holds them stable until the memory signals completion.
- Returns read data and a one-cycle ack to the winning requester.
- Produces a pipeline stall for the core while any request is still outstanding.

Parameters:
- MAX_DM_BURST, 4, maximum consecutive DM grants while IM is waiting before IM is forced to win. Legal range is 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- im_req  input  1  instruction-fetch request; held until im_ack
- im_addr  input  32  fetch byte address
- im_ack  output  1  one-cycle completion pulse to IF
- im_rdata  output  32  fetched word, registered
- dm_req  input  1  data request (MEM_CS equivalent); held until dm_ack
- dm_write  input  1  1 = store, 0 = load
- dm_type  input  3  access type code (CACHE_WORD/BYTE/HWORD/BYTE_U/HWORD_U from def.svh)
- dm_addr  input  32  data byte address
- dm_wdata  input  32  lane-aligned store data
- dm_ack  output  1  one-cycle completion pulse to MEM
- dm_rdata  output  32  load data, registered, raw (unextended)
- mem_req  output  1  request to shared port
- mem_write  output  1  registered write flag
- mem_type  output  3  registered access type
- mem_addr  output  32  registered address
- mem_wdata  output  32  registered store data
- mem_rdata  input  32  port read data, valid with mem_valid
- mem_valid  input  1  port completion, one-cycle pulse
- core_stall  output  1  (im_req & ~im_ack) | (dm_req & ~dm_ack)

Behaviour:
- Reset (async, rst=1): FSM=IDLE. mem_req, im_ack, dm_ack = 0. im_rdata, dm_rdata, mem_addr, mem_wdata = 0. mem_write = 0. mem_type = CACHE_WORD. dm_streak = 0. Reset mid-transaction abandons it; a later mem_valid is ignored.
- States are IDLE, BUSY_IM, BUSY_DM, RESP.
- IDLE, grant decision on the clock edge:
  - dm_req only: go to BUSY_DM.
  - im_req only: go to BUSY_IM.
  - Both: DM wins unless dm_streak == MAX_DM_BURST, in which case IM wins.
  - Neither: stay in IDLE.
- On grant, latch the winner's fields into mem_*:
  - IM grant: mem_write=0, mem_type=CACHE_WORD, mem_addr=im_addr, mem_wdata=0.
  - DM grant: dm_* fields copied directly.
- mem_req=1 for the whole BUSY_* state. mem_* must stay constant while mem_req=1.
- BUSY_x: wait for mem_valid. When it arrives:
  - Capture mem_rdata into im_rdata (IM), or into dm_rdata (DM load only; stores leave dm_rdata unchanged).
  - Go to RESP with the matching ack register set.
- RESP: exactly one cycle.
  - The matching ack=1 and mem_req=0.
  - No grant is made in this cycle, even if requests are pending.
  - The requester drops or changes req at the end of RESP.
  - Next state is IDLE.
- mem_valid is ignored in IDLE and RESP.
- Minimum latency, grant to ack: memory latency L cycles in BUSY, plus 1 RESP cycle. Back-to-back transactions have a period of L+2.
- dm_streak (4-bit):
  - Increments on each DM grant made while im_req=1, saturating at MAX_DM_BURST.
  - Clears on any IM grant.
  - Clears on a DM grant made while im_req=0.
- core_stall is combinational from the req inputs and registered acks. It is low during a RESP cycle for the acked requester only.
- dm_type and the address are passed through unmodified. Byte-lane placement and sign extension belong to the MEM stage.

Test Plan:
- Single DM load: dm_req=1, dm_write=0, dm_addr=0x0000_0104, memory returns 0xDEADBEEF after 2 cycles.
  - Required: mem_addr=0x104 from the cycle after request.
  - dm_ack pulses once, the cycle after mem_valid.
  - dm_rdata=0xDEADBEEF; core_stall low only in the ack cycle.
- Simultaneous requests, both held continuously, MAX_DM_BURST=4, L=1.
  - Required grant order: DM, DM, DM, DM, IM, DM...
  - dm_streak returns to 0 after the IM grant.
- DM store with byte type: dm_write=1, dm_type=CACHE_BYTE, dm_wdata=0x0000_AB00.
  - Required: mem_write=1 and mem_type=CACHE_BYTE for the whole BUSY state.
  - dm_rdata keeps its prior value.
- Input change while busy: change dm_addr after grant, before mem_valid.
  - Required: mem_addr stays at the latched value.
- Stray mem_valid in IDLE and in RESP.
  - Required: no ack, no rdata update.
- Reset mid-transaction: rst=1 in BUSY_IM with a mem_valid pulse one cycle later.
  - Required: all outputs at reset values immediately, FSM in IDLE, no im_ack.
